// File: rtl/conv_transpose_stream_if.sv
// Handshake and kernel-load bundle for conv_transpose_stream.
// The slave side is the engine; the master side is its upstream/downstream driver.
interface conv_transpose_stream_if #(
  parameter int BIT_REP_IN  = 8,
  parameter int BIT_REP_OUT = 8,
  parameter int KA_W        = 4
);
  logic                          k_we;
  logic [KA_W-1:0]               k_addr;
  logic signed [BIT_REP_IN-1:0]  k_data;
  logic                          in_valid;
  logic                          in_ready;
  logic signed [BIT_REP_IN-1:0]  in_data;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [BIT_REP_OUT-1:0] out_data;
  logic                          frame_done;
  logic                          busy;

  modport master (
    output k_we, k_addr, k_data, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, frame_done, busy
  );

  modport slave (
    input  k_we, k_addr, k_data, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, frame_done, busy
  );
endinterface

// File: rtl/conv_transpose_stream.sv
// Stride-1 transposed convolution: scatters each raster-order input pixel through a
// KxK kernel into a frame-sized accumulator, then drains a requantised cropped frame.
module conv_transpose_stream #(
  parameter int BIT_REP_IN  = 8,
  parameter int BIT_REP_OUT = 8,
  parameter int IN_LENGTH   = 8,
  parameter int IN_WIDTH    = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int ACC_W       = 24,
  parameter int OUT_SHIFT   = 8
) (
  input logic                   clk,
  input logic                   rst,
  conv_transpose_stream_if.slave bus
);
  localparam int KK   = KERNEL_SIZE * KERNEL_SIZE;
  localparam int PAD  = (KERNEL_SIZE - 1) / 2;
  localparam int KA_W = (KK > 1) ? $clog2(KK) : 1;
  localparam int RW   = (IN_LENGTH > 1) ? $clog2(IN_LENGTH) : 1;
  localparam int CW   = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int UW   = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int PW   = 2 * BIT_REP_IN;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (BIT_REP_OUT - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {ACCEPT, SCATTER, DRAIN} state_t;

  state_t                        state_q, state_d;
  logic [RW-1:0]                 pr_q, pr_d, dr_q, dr_d;
  logic [CW-1:0]                 pc_q, pc_d, dc_q, dc_d;
  logic [UW-1:0]                 u_q, u_d, v_q, v_d;
  logic signed [BIT_REP_IN-1:0]  x_q, x_d;
  logic signed [BIT_REP_IN-1:0]  kern_q [KK];
  logic signed [BIT_REP_IN-1:0]  kern_d [KK];
  logic signed [ACC_W-1:0]       acc_q [IN_LENGTH][IN_WIDTH];
  logic signed [ACC_W-1:0]       acc_d [IN_LENGTH][IN_WIDTH];
  logic                          fd_q, fd_d;

  logic                          busy, in_fire, out_fire, last_mac, last_pix, last_out, tgt_ok;
  logic [KA_W-1:0]               kidx;
  int                            tr, tc;
  logic signed [PW-1:0]          prod;
  logic signed [ACC_W-1:0]       prod_ext, rd_acc, shifted, clamped;

  // pr/pc count pixels of the frame; nonzero while ACCEPT means a frame is in flight
  assign busy     = (state_q != ACCEPT) || (pr_q != '0) || (pc_q != '0);
  assign in_fire  = bus.in_valid && (state_q == ACCEPT);
  assign out_fire = bus.out_ready && (state_q == DRAIN);
  assign last_mac = (u_q == UW'(KERNEL_SIZE - 1)) && (v_q == UW'(KERNEL_SIZE - 1));
  assign last_pix = (pr_q == RW'(IN_LENGTH - 1)) && (pc_q == CW'(IN_WIDTH - 1));
  assign last_out = (dr_q == RW'(IN_LENGTH - 1)) && (dc_q == CW'(IN_WIDTH - 1));

  assign kidx     = KA_W'(int'(u_q) * KERNEL_SIZE + int'(v_q));
  assign tr       = int'(pr_q) + PAD - int'(u_q);
  assign tc       = int'(pc_q) + PAD - int'(v_q);
  assign tgt_ok   = (tr >= 0) && (tr < IN_LENGTH) && (tc >= 0) && (tc < IN_WIDTH);
  assign prod     = PW'(x_q) * PW'(kern_q[kidx]);
  assign prod_ext = ACC_W'(prod);

  assign rd_acc   = acc_q[dr_q][dc_q];
  assign shifted  = rd_acc >>> OUT_SHIFT;
  assign clamped  = (shifted > SAT_MAX) ? SAT_MAX : ((shifted < SAT_MIN) ? SAT_MIN : shifted);

  assign bus.in_ready   = (state_q == ACCEPT);
  assign bus.out_valid  = (state_q == DRAIN);
  assign bus.out_data   = (state_q == DRAIN) ? BIT_REP_OUT'(clamped) : '0;
  assign bus.frame_done = fd_q;
  assign bus.busy       = busy;

  always_comb begin
    state_d = state_q;
    pr_d    = pr_q;
    pc_d    = pc_q;
    dr_d    = dr_q;
    dc_d    = dc_q;
    u_d     = u_q;
    v_d     = v_q;
    x_d     = x_q;
    kern_d  = kern_q;
    acc_d   = acc_q;
    fd_d    = 1'b0;
    unique case (state_q)
      ACCEPT: begin
        // a weight write racing the first pixel of a frame loses
        if (in_fire) begin
          x_d     = bus.in_data;
          u_d     = '0;
          v_d     = '0;
          state_d = SCATTER;
        end else if (bus.k_we && !busy && (int'(bus.k_addr) < KK)) begin
          kern_d[bus.k_addr] = bus.k_data;
        end
      end
      SCATTER: begin
        if (tgt_ok) acc_d[RW'(tr)][CW'(tc)] = acc_q[RW'(tr)][CW'(tc)] + prod_ext;
        if (v_q == UW'(KERNEL_SIZE - 1)) begin
          v_d = '0;
          u_d = u_q + 1'b1;
        end else begin
          v_d = v_q + 1'b1;
        end
        if (last_mac) begin
          u_d = '0;
          if (last_pix) begin
            pr_d    = '0;
            pc_d    = '0;
            state_d = DRAIN;
          end else begin
            state_d = ACCEPT;
            if (pc_q == CW'(IN_WIDTH - 1)) begin
              pc_d = '0;
              pr_d = pr_q + 1'b1;
            end else begin
              pc_d = pc_q + 1'b1;
            end
          end
        end
      end
      DRAIN: begin
        // clearing on transfer leaves the array ready for the next frame
        if (out_fire) begin
          acc_d[dr_q][dc_q] = '0;
          if (last_out) begin
            dr_d    = '0;
            dc_d    = '0;
            fd_d    = 1'b1;
            state_d = ACCEPT;
          end else if (dc_q == CW'(IN_WIDTH - 1)) begin
            dc_d = '0;
            dr_d = dr_q + 1'b1;
          end else begin
            dc_d = dc_q + 1'b1;
          end
        end
      end
      default: state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCEPT;
      pr_q    <= '0;
      pc_q    <= '0;
      dr_q    <= '0;
      dc_q    <= '0;
      u_q     <= '0;
      v_q     <= '0;
      x_q     <= '0;
      kern_q  <= '{default: '0};
      acc_q   <= '{default: '0};
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pr_q    <= pr_d;
      pc_q    <= pc_d;
      dr_q    <= dr_d;
      dc_q    <= dc_d;
      u_q     <= u_d;
      v_q     <= v_d;
      x_q     <= x_d;
      kern_q  <= kern_d;
      acc_q   <= acc_d;
      fd_q    <= fd_d;
    end
  end
endmodule

// File: doc/conv_transpose_stream.md
Name: conv_transpose_stream

Overview:
Streaming stride-1 transposed convolution (deconvolution) engine: the decoder-side counterpart of the zero-padding spatial convolution.
- Accepts an IN_LENGTH x IN_WIDTH feature map one pixel per handshake, in raster order.
- Scatters each pixel through a KERNEL_SIZE x KERNEL_SIZE kernel into an on-chip accumulator array.
- Drains the same-size cropped result as a requantised output stream.
- Sits between a DotProduct/convolution stage and the next layer or frame sink.

Parameters:
BIT_REP_IN, 8, signed width of input pixels and kernel weights
BIT_REP_OUT, 8, signed width of output pixels
IN_LENGTH, 8, rows per frame (input and output)
IN_WIDTH, 8, columns per frame (input and output)
KERNEL_SIZE, 3, kernel edge; must be odd and >=1; PADDING=(KERNEL_SIZE-1)/2
ACC_W, 24, signed accumulator width
OUT_SHIFT, 8, arithmetic right shift applied before saturation to BIT_REP_OUT

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
k_we  in  1  kernel weight write strobe
k_addr  in  clog2(KERNEL_SIZE*KERNEL_SIZE)  weight index u*KERNEL_SIZE+v
k_data  in  BIT_REP_IN  signed weight
in_valid  in  1  input pixel valid
in_ready  out  1  block can accept input pixel
in_data  in  BIT_REP_IN  signed input pixel
out_valid  out  1  output pixel valid
out_ready  in  1  downstream accepts output pixel
out_data  out  BIT_REP_OUT  signed output pixel, raster order
frame_done  out  1  one-cycle pulse after last output pixel transfers
busy  out  1  high in SCATTER or DRAIN, or in ACCEPT with >=1 pixel received

Behaviour:
- Reset values:
  - state=ACCEPT; all counters 0; all accumulators 0; all kernel weights 0.
  - in_ready=1, out_valid=0, out_data=0, frame_done=0, busy=0.
- States:
  - ACCEPT: in_ready=1. A transfer (in_valid&in_ready) latches the pixel and its (r,c), then moves to SCATTER.
  - SCATTER: in_ready=0. Exactly KERNEL_SIZE*KERNEL_SIZE cycles, one MAC per cycle, iterating u outer and v inner, 0..K-1.
    - Target is out(r+PADDING-u, c+PADDING-v) += x*k[u][v].
    - Targets outside 0..IN_LENGTH-1 / 0..IN_WIDTH-1 are discarded; the cycle is still consumed.
    - After the last MAC: if (r,c) was the last pixel, go to DRAIN; else return to ACCEPT.
  - DRAIN: out_valid=1 with out_data=sat(acc[i][j]>>>OUT_SHIFT), raster order starting at (0,0).
    - On out_valid&out_ready, clear acc[i][j] to 0 and advance.
    - out_data and out_valid are held stable while out_ready=0.
    - After transfer of (IN_LENGTH-1, IN_WIDTH-1): frame_done=1 for the next cycle, and state returns to ACCEPT in that same cycle.
- Throughput: one input pixel per K*K+1 cycles max; in_ready is low during SCATTER.
- Arithmetic:
  - Product is signed 2*BIT_REP_IN bits, sign-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W.
  - Shift is arithmetic.
  - Saturation clamps to [-2^(BIT_REP_OUT-1), 2^(BIT_REP_OUT-1)-1].
- Kernel writes:
  - Honoured only when state=ACCEPT and busy=0 (between frames).
  - Silently ignored otherwise, including a k_we that coincides with the first pixel transfer.
  - A write takes effect for MACs starting the next cycle.
- Boundary conditions:
  - in_valid high with in_ready low: no transfer; upstream holds data.
  - KERNEL_SIZE=1: SCATTER is 1 cycle; output = sat(x*k[0][0]>>>OUT_SHIFT).
  - Reset mid-SCATTER or mid-DRAIN: immediately returns to reset values. The partial frame is lost and accumulators are cleared; the kernel is also cleared and must be reloaded.
  - out_ready held high: one output per cycle; a frame drains in IN_LENGTH*IN_WIDTH cycles.

Test Plan:
- Identity kernel (k[1][1]=1, others 0), OUT_SHIFT=0, 8x8 ramp input 0..63 → output ramp 0..63 in raster order; frame_done pulses once; busy falls afterwards.
- Kernel k[u][v]=3u+v+1, OUT_SHIFT=0, impulse 2 at (0,0), all other pixels 0 → out(0,0)=10, out(0,1)=8, out(1,0)=4, out(1,1)=2, all others 0.
- All weights 127, all pixels 127, OUT_SHIFT=0 → interior outputs saturate to 127. All weights -128, pixels 127 → interior outputs -128.
- out_ready toggling 1,0,0,1 during DRAIN → out_data stable while stalled; no pixel skipped or duplicated; 64 transfers total.
- k_we with k_data=5 during SCATTER of pixel 3 → ignored; frame result matches the prior kernel. The same write between frames → takes effect in the next frame.
- Assert rst mid-SCATTER on pixel 10 → in_ready=1, out_valid=0, busy=0 immediately. Full frame after reload matches golden with no residue from the aborted frame.
